// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns: one column per cycle through a shared column datapath.
// Valid/ready on both sides; a final-round bypass flag copies the state through with identical timing.
module mix_columns_iter #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q;
  logic [3:0][31:0] cap_q;      // index 3 holds column 0 ([127:96])
  logic [3:0][31:0] res_q;
  logic             cap_byp_q;
  logic             init_q;     // keeps in_ready low until the first edge after reset release
  logic             accept;
  logic [31:0]      col_in, col_mix, col_res;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] b);
    m2 = xt(b);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] b);
    m3 = xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    m9 = xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] b);
    mb = xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] b);
    md = xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] b);
    me = xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  assign in_ready  = init_q && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = res_q;

  assign col_in = cap_q[2'd3 - cnt_q];

  logic [7:0] s0, s1, s2, s3;
  assign {s0, s1, s2, s3} = col_in;

  generate
    if (INVERSE) begin : g_inv
      assign col_mix = {me(s0) ^ mb(s1) ^ md(s2) ^ m9(s3),
                        m9(s0) ^ me(s1) ^ mb(s2) ^ md(s3),
                        md(s0) ^ m9(s1) ^ me(s2) ^ mb(s3),
                        mb(s0) ^ md(s1) ^ m9(s2) ^ me(s3)};
    end else begin : g_fwd
      assign col_mix = {m2(s0) ^ m3(s1) ^ s2     ^ s3,
                        s0     ^ m2(s1) ^ m3(s2) ^ s3,
                        s0     ^ s1     ^ m2(s2) ^ m3(s3),
                        m3(s0) ^ s1     ^ s2     ^ m2(s3)};
    end
  endgenerate

  assign col_res = cap_byp_q ? col_in : col_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      cnt_q     <= 2'd0;
      cap_q     <= '0;
      cap_byp_q <= 1'b0;
      res_q     <= '0;
    end else begin
      init_q <= 1'b1;
      if (state_q == IDLE && accept) begin
        cap_q     <= in_state;
        cap_byp_q <= in_bypass;
        cnt_q     <= 2'd0;
      end else if (state_q == CALC) begin
        res_q[2'd3 - cnt_q] <= col_res;
        cnt_q               <= cnt_q + 2'd1;
      end
    end
  end

endmodule
